conv_frame_scheduler: RTL and testbench

Frame-level controller for the 3x3 convolution pipeline (line buffer, convolution, output FIFO). It holds a set of kernel weight banks and a small queue of frame jobs. For each job it loads the selected kernel, pulses `start`, holds `run` while the input frame streams, and waits for the output frame to drain. It monitors stream beats to check line and frame geometry and reports completion and errors to the host-side register logic.

---
 rtl/conv_frame_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_scheduler
// Brief    : Job queue and frame FSM for the 3x3 convolution pipeline, with
//            stream geometry checks. Optional drain watchdog: SCHED_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module conv_frame_scheduler #(
    parameter int IMAGE_WIDTH_SIZE       = 512,
    parameter int IMAGE_WIDTH_LOG2_SIZE  = 9,
    parameter int IMAGE_HEIGHT_SIZE      = 512,
    parameter int IMAGE_HEIGHT_LOG2_SIZE = 9,
    parameter int NUM_BANKS              = 4,
    parameter int JOB_FIFO_DEPTH         = 4,
    parameter int JOB_FIFO_LOG2_DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_bank,
    input  logic [26:0] cfg_weights,
    input  logic        job_valid,
    input  logic [1:0]  job_bank,
    output logic        job_ready,
    input  logic        in_beat,
    input  logic        in_eol,
    input  logic        in_tlast,
    input  logic        out_beat,
    input  logic        out_tlast,
    output logic        start,
    output logic        run,
    output logic [26:0] filter_weights,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    input  logic        err_clr,
    output logic [7:0]  jobs_done
);
    localparam int PIX_W = IMAGE_WIDTH_LOG2_SIZE + IMAGE_HEIGHT_LOG2_SIZE;
    localparam int CNT_W = JOB_FIFO_LOG2_DEPTH + 1;
    localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(IMAGE_WIDTH_SIZE * IMAGE_HEIGHT_SIZE - 1);
    localparam logic [PIX_W-1:0] c_PIX_MAX  = '1;
    localparam logic [IMAGE_WIDTH_LOG2_SIZE-1:0] c_COL_LAST = IMAGE_WIDTH_LOG2_SIZE'(IMAGE_WIDTH_SIZE - 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(JOB_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                           r_state, w_next;
    logic [26:0]                      r_bank [NUM_BANKS];
    logic [1:0]                       r_fifo [JOB_FIFO_DEPTH];
    logic [JOB_FIFO_LOG2_DEPTH-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]                 r_count, w_count_next;
    logic [1:0]                       r_load_bank;
    logic [IMAGE_WIDTH_LOG2_SIZE-1:0] r_col;
    logic [PIX_W-1:0]                 r_pix;
    logic                             r_job_ready, r_start, r_run, r_busy, r_done;
    logic [26:0]                      r_filter_weights;
    logic [2:0]                       r_err, w_err_set;
    logic [7:0]                       r_jobs_done;
    logic                             w_push, w_pop, w_run_beat, w_wd_expire;

    assign w_push     = job_valid && r_job_ready;
    assign w_run_beat = (r_state == S_RUN) && in_beat;

`ifdef SCHED_WATCHDOG_EN
    logic [15:0] r_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wd <= '0;
        else if (r_state != S_DRAIN || out_beat)
            r_wd <= '0;
        else
            r_wd <= r_wd + 16'd1;
    end

    // r_wd holds the idle cycles already elapsed; this cycle is idle number 65535
    assign w_wd_expire = (r_state == S_DRAIN) && !out_beat && (r_wd == 16'hFFFE);
`else
    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next = S_LOAD;
                    w_pop  = 1'b1;
                end
            end
            S_LOAD:  w_next = S_ARM;
            S_ARM:   w_next = S_RUN;
            S_RUN:   if (in_beat && in_tlast) w_next = S_DRAIN;
            S_DRAIN: if ((out_beat && out_tlast) || w_wd_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_err_set    = 3'b000;
        w_err_set[0] = w_run_beat && in_eol && (r_col != c_COL_LAST);
        // Too short at tlast, or a non-final beat at/after the last pixel index
        w_err_set[1] = w_run_beat && (in_tlast ? (r_pix != c_PIX_LAST) : (r_pix >= c_PIX_LAST));
        w_err_set[2] = w_wd_expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_run   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == S_ARM);
            r_run   <= (w_next == S_RUN);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++)
                r_bank[i] <= '0;
        end else if (cfg_we) begin
            r_bank[cfg_bank] <= cfg_weights;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= job_bank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_job_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_job_ready <= (w_count_next != c_DEPTH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_bank      <= '0;
            r_filter_weights <= '0;
            r_col            <= '0;
            r_pix            <= '0;
            r_err            <= '0;
            r_jobs_done      <= '0;
        end else begin
            if (w_pop)
                r_load_bank <= r_fifo[r_rd_ptr];
            if (r_state == S_LOAD) begin
                r_filter_weights <= r_bank[r_load_bank];
                r_col            <= '0;
                r_pix            <= '0;
            end else if (w_run_beat) begin
                r_col <= in_eol ? '0 : r_col + 1'b1;
                if (r_pix != c_PIX_MAX)
                    r_pix <= r_pix + 1'b1;
            end
            r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
            if (r_state == S_DONE)
                r_jobs_done <= r_jobs_done + 8'd1;
        end
    end

    assign job_ready      = r_job_ready;
    assign start          = r_start;
    assign run            = r_run;
    assign busy           = r_busy;
    assign done           = r_done;
    assign filter_weights = r_filter_weights;
    assign err            = r_err;
    assign jobs_done      = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_scheduler
// Brief    : Scoreboard bench for conv_frame_scheduler on a 4x3 frame geometry.
// Revision : 1.0
// ============================================================================
module tb_conv_frame_scheduler;
    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_bank = 2'd0;
    logic [26:0] cfg_weights = 27'd0;
    logic        job_valid = 1'b0;
    logic [1:0]  job_bank = 2'd0;
    logic        job_ready;
    logic        in_beat = 1'b0, in_eol = 1'b0, in_tlast = 1'b0;
    logic        out_beat = 1'b0, out_tlast = 1'b0;
    logic        start, run, busy, done;
    logic [26:0] filter_weights;
    logic [2:0]  err;
    logic        err_clr = 1'b0;
    logic [7:0]  jobs_done;

    int          checks = 0;
    int          failures = 0;
    int          exp_jobs = 0;
    logic [26:0] q_fw [$];
    logic [26:0] m_bank [4];

    conv_frame_scheduler #(
        .IMAGE_WIDTH_SIZE(W), .IMAGE_WIDTH_LOG2_SIZE(2),
        .IMAGE_HEIGHT_SIZE(H), .IMAGE_HEIGHT_LOG2_SIZE(2),
        .NUM_BANKS(4), .JOB_FIFO_DEPTH(4), .JOB_FIFO_LOG2_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_bank(cfg_bank),
        .cfg_weights(cfg_weights), .job_valid(job_valid), .job_bank(job_bank),
        .job_ready(job_ready), .in_beat(in_beat), .in_eol(in_eol),
        .in_tlast(in_tlast), .out_beat(out_beat), .out_tlast(out_tlast),
        .start(start), .run(run), .filter_weights(filter_weights), .busy(busy),
        .done(done), .err(err), .err_clr(err_clr), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    // Every start pulse must present the weights queued for that job
    always begin : mon_start
        logic [26:0] e;
        @(posedge clk);
        #1;
        if (start === 1'b1) begin
            checks++;
            if (q_fw.size() == 0) begin
                failures++;
                $display("FAIL start_unexpected got start=1 required no pending job");
            end else begin
                e = q_fw.pop_front();
                if (filter_weights !== e) begin
                    failures++;
                    $display("FAIL start_weights got=%h required=%h", filter_weights, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int b, input logic [26:0] v);
        cfg_we = 1'b1; cfg_bank = 2'(b); cfg_weights = v;
        step();
        cfg_we = 1'b0;
        m_bank[b] = v;
    endtask

    task automatic push_job(input int b);
        int n = 0;
        job_valid = 1'b1; job_bank = 2'(b);
        q_fw.push_back(m_bank[b]);
        while (job_ready !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (job_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_job_ready got=%b required=1", job_ready);
        end
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (run !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (run !== 1'b1) begin
            failures++;
            $display("FAIL wait_run got run=%b required=1", run);
        end
    endtask

    // Stalls every fifth slot with junk eol/tlast that must be ignored
    task automatic send_frame(input int npix, input int bad_eol_pix);
        int col = 0;
        for (int p = 0; p < npix; p++) begin
            if (p % 5 == 4) begin
                in_beat = 1'b0; in_eol = 1'b1; in_tlast = 1'b1;
                step();
            end
            in_beat  = 1'b1;
            in_eol   = (col == W - 1) || (p == bad_eol_pix);
            in_tlast = (p == npix - 1);
            col      = in_eol ? 0 : col + 1;
            step();
        end
        in_beat = 1'b0; in_eol = 1'b0; in_tlast = 1'b0;
    endtask

    task automatic drain();
        out_beat = 1'b1; out_tlast = 1'b0;
        step();
        out_beat = 1'b0;
        step();
        out_beat = 1'b1; out_tlast = 1'b1;
        step();
        out_beat = 1'b0; out_tlast = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL drain_done_pulse got=%b required=1", done);
        end
        exp_jobs++;
        step();
        checks++;
        if ({done, busy, jobs_done} !== {1'b0, 1'b0, 8'(exp_jobs)}) begin
            failures++;
            $display("FAIL drain_after got done=%b busy=%b jobs=%0d required 0 0 %0d",
                     done, busy, jobs_done, exp_jobs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({start, run, busy, done, err, jobs_done, filter_weights, job_ready} !==
            {4'b0, 3'b0, 8'd0, 27'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values got s%b r%b b%b d%b e%b j%0d w%h rdy%b",
                     start, run, busy, done, err, jobs_done, filter_weights, job_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_bank[i] = 27'd0;
        step(); step();
        checks++;
        if ({busy, job_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_release got busy=%b ready=%b required 0 1", busy, job_ready);
        end
    endtask

    task automatic test_first_job();
        cfg_write(2, 27'h1000);
        job_valid = 1'b1; job_bank = 2'd2;
        q_fw.push_back(27'h1000);
        step();
        job_valid = 1'b0;
        checks++;
        if ({start, busy} !== 2'b00) begin
            failures++;
            $display("FAIL first_c1 got start=%b busy=%b required 0 0", start, busy);
        end
        step();
        checks++;
        if ({start, busy, run} !== 3'b010) begin
            failures++;
            $display("FAIL first_c2 got start=%b busy=%b run=%b required 0 1 0", start, busy, run);
        end
        step();
        checks++;
        if ({start, run, filter_weights} !== {2'b10, 27'h1000}) begin
            failures++;
            $display("FAIL first_c3 got start=%b run=%b w=%h required 1 0 1000",
                     start, run, filter_weights);
        end
        step();
        checks++;
        if ({start, run} !== 2'b01) begin
            failures++;
            $display("FAIL first_c4 got start=%b run=%b required 0 1", start, run);
        end
        send_frame(W * H, -1);
        drain();
    endtask

    task automatic test_full_frame();
        cfg_write(3, 27'h5A5A5A5);
        push_job(3);
        wait_run();
        send_frame(W * H, -1);
        checks++;
        if ({run, busy} !== 2'b01) begin
            failures++;
            $display("FAIL full_after_tlast got run=%b busy=%b required 0 1", run, busy);
        end
        drain();
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL full_err got=%b required=000", err);
        end
    endtask

    task automatic test_geometry();
        push_job(2);
        wait_run();
        send_frame(11, 2);
        drain();
        checks++;
        if (err !== 3'b011) begin
            failures++;
            $display("FAIL geom_short_err got=%b required=011", err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL geom_err_clr got=%b required=000", err);
        end
        push_job(2);
        wait_run();
        send_frame(W * H + 1, -1);
        drain();
        checks++;
        if (err !== 3'b010) begin
            failures++;
            $display("FAIL geom_long_err got=%b required=010", err);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        cfg_write(0, 27'h0000A01);
        cfg_write(1, 27'h0000B02);
        cfg_write(2, 27'h0000C03);
        cfg_write(3, 27'h0000D04);
        push_job(0);
        wait_run();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (job_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got=%b required=1", i, job_ready);
            end
            job_valid = 1'b1; job_bank = 2'(i);
            q_fw.push_back(m_bank[i]);
            step();
        end
        job_bank = 2'd1;
        q_fw.push_back(m_bank[1]);
        step(); step();
        checks++;
        if (job_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fifth_blocked got ready=%b required=0", job_ready);
        end
        send_frame(W * H, -1);
        drain();
        while (job_ready !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (job_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fifth_unblock got ready=%b required=1", job_ready);
        end
        step();
        job_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            wait_run();
            send_frame(W * H, -1);
            drain();
        end
    endtask

    task automatic test_bank_rewrite();
        cfg_write(1, 27'h1234567);
        push_job(1);
        wait_run();
        cfg_write(1, 27'h7654321);
        push_job(1);
        send_frame(W * H, -1);
        checks++;
        if (filter_weights !== 27'h1234567) begin
            failures++;
            $display("FAIL rewrite_current got=%h required=1234567", filter_weights);
        end
        drain();
        wait_run();
        checks++;
        if (filter_weights !== 27'h7654321) begin
            failures++;
            $display("FAIL rewrite_next got=%h required=7654321", filter_weights);
        end
        send_frame(W * H, -1);
        drain();
    endtask

    task automatic test_reset_mid_run();
        push_job(0);
        wait_run();
        push_job(2);
        in_beat = 1'b1;
        step(); step();
        in_beat = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({start, run, busy, done, err, jobs_done, filter_weights, job_ready} !==
            {4'b0, 3'b0, 8'd0, 27'd0, 1'b1}) begin
            failures++;
            $display("FAIL midrun_reset got s%b r%b b%b d%b e%b j%0d w%h rdy%b",
                     start, run, busy, done, err, jobs_done, filter_weights, job_ready);
        end
        q_fw.delete();
        for (int i = 0; i < 4; i++) m_bank[i] = 27'd0;
        exp_jobs = 0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if ({busy, done, jobs_done} !== {2'b00, 8'd0}) begin
            failures++;
            $display("FAIL midrun_discard got busy=%b done=%b jobs=%0d required 0 0 0",
                     busy, done, jobs_done);
        end
    endtask

`ifdef SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int n = 0;
        push_job(0);
        wait_run();
        send_frame(W * H, -1);
        while (done !== 1'b1 && n < 70000) begin step(); n++; end
        checks++;
        if (done !== 1'b1 || n != 65535 || err[2] !== 1'b1) begin
            failures++;
            $display("FAIL watchdog got done=%b cycles=%0d err=%b required 1 65535 1xx",
                     done, n, err);
        end
        exp_jobs++;
        step();
        checks++;
        if (jobs_done !== 8'(exp_jobs)) begin
            failures++;
            $display("FAIL watchdog_jobs got=%0d required=%0d", jobs_done, exp_jobs);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) m_bank[i] = 27'd0;
        test_reset();
        test_first_job();
        test_full_frame();
        test_geometry();
        test_back_to_back();
        test_bank_rewrite();
        test_reset_mid_run();
`ifdef SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        step(); step(); step(); step();
        checks++;
        if (q_fw.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d pending required=0", q_fw.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
